// File: rtl/rst_pulse_gen.sv
//------------------------------------------------------------------------------
// Module      : rst_pulse_gen
// Description : Request-driven reset pulse generator with power-on pulse,
//               post-release holdoff and a single-cycle completion strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rst_pulse_gen #(
   parameter int PULSE_CYCLES   = 128,
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic clk_i,
   input  logic arst_n_i,
   input  logic req_i,
   output logic rst_n_o,
   output logic busy_o,
   output logic done_o
);

   localparam int c_CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam bit c_HAS_HOLDOFF = (HOLDOFF_CYCLES > 0);
   localparam int c_HOLD_LAST_INT = c_HAS_HOLDOFF ? (HOLDOFF_CYCLES - 1) : 0;

   localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(c_HOLD_LAST_INT);
   localparam logic [c_CNT_W-1:0] c_CNT_ZERO   = '0;
   localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

   generate
      if (PULSE_CYCLES < 1) begin : g_bad_pulse
         $error("rst_pulse_gen: PULSE_CYCLES must be >= 1");
      end
      if (HOLDOFF_CYCLES < 0) begin : g_bad_holdoff
         $error("rst_pulse_gen: HOLDOFF_CYCLES must be >= 0");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_CNT_W-1:0]   w_cnt_nxt;
   logic                 r_req_q;
   logic                 r_rst_n;
   logic                 w_rst_n_nxt;
   logic                 r_done;
   logic                 w_done_nxt;
   logic                 w_req_edge;

   assign w_req_edge = req_i & ~r_req_q;

   // Reset lands in ASSERT so release immediately runs the power-on pulse.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state <= ST_ASSERT;
         r_cnt   <= c_CNT_ZERO;
         r_req_q <= 1'b0;
         r_rst_n <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req_q <= req_i;
         r_rst_n <= w_rst_n_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rst_n_nxt = r_rst_n;
      w_done_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_rst_n_nxt = 1'b1;
            if (w_req_edge) begin
               w_state_nxt = ST_ASSERT;
               w_cnt_nxt   = c_CNT_ZERO;
               w_rst_n_nxt = 1'b0;
            end
         end

         ST_ASSERT: begin
            w_rst_n_nxt = 1'b0;
            if (r_cnt == c_PULSE_LAST) begin
               w_cnt_nxt   = c_CNT_ZERO;
               w_rst_n_nxt = 1'b1;
               if (c_HAS_HOLDOFF) begin
                  w_state_nxt = ST_HOLDOFF;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end

         ST_HOLDOFF: begin
            w_rst_n_nxt = 1'b1;
            if (r_cnt == c_HOLD_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = c_CNT_ZERO;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end

         default: begin
            // Unreachable encoding recovers by issuing a full pulse.
            w_state_nxt = ST_ASSERT;
            w_cnt_nxt   = c_CNT_ZERO;
            w_rst_n_nxt = 1'b0;
         end
      endcase
   end

   assign rst_n_o = r_rst_n;
   assign busy_o  = (r_state != ST_IDLE);
   assign done_o  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rst_pulse_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_rst_pulse_gen
// Description : Randomized self-checking bench for rst_pulse_gen (two configs).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rst_pulse_gen;

   localparam int c_P_A = 4;
   localparam int c_H_A = 2;
   localparam int c_P_B = 1;
   localparam int c_H_B = 0;

   logic clk_i    = 1'b0;
   logic arst_n_i = 1'b0;
   logic req_a    = 1'b0;
   logic req_b    = 1'b0;
   logic rst_n_a, busy_a, done_a;
   logic rst_n_b, busy_b, done_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: a pulse is described only by the cycle its first low cycle falls in.
   int pcyc  [2] = '{c_P_A, c_P_B};
   int hcyc  [2] = '{c_H_A, c_H_B};
   int start [2] = '{0, 0};
   bit have  [2] = '{1'b0, 1'b0};
   bit prev  [2] = '{1'b0, 1'b0};

   rst_pulse_gen #(.PULSE_CYCLES(c_P_A), .HOLDOFF_CYCLES(c_H_A)) u_dut_a (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .req_i    (req_a),
      .rst_n_o  (rst_n_a),
      .busy_o   (busy_a),
      .done_o   (done_a)
   );

   rst_pulse_gen #(.PULSE_CYCLES(c_P_B), .HOLDOFF_CYCLES(c_H_B)) u_dut_b (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .req_i    (req_b),
      .rst_n_o  (rst_n_b),
      .busy_o   (busy_b),
      .done_o   (done_b)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_out(input int i, input int k,
                                     output bit e_rst_n, output bit e_busy, output bit e_done);
      int rel;
      e_rst_n = 1'b1;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      if (have[i]) begin
         rel = k - start[i];
         if (rel >= 0 && rel < pcyc[i]) begin
            e_rst_n = 1'b0;
            e_busy  = 1'b1;
         end else if (rel >= pcyc[i] && rel < pcyc[i] + hcyc[i]) begin
            e_busy  = 1'b1;
         end else if (rel == pcyc[i] + hcyc[i]) begin
            e_done  = 1'b1;
         end
      end
   endfunction

   task automatic check_inst(input int i, input bit req, input logic g_rst_n,
                             input logic g_busy, input logic g_done);
      bit e_rst_n, e_busy, e_done;
      string sfx;
      sfx = (i == 0) ? "_a" : "_b";
      model_out(i, cyc, e_rst_n, e_busy, e_done);
      check_eq({"rst_n", sfx}, 32'(g_rst_n), 32'(e_rst_n));
      check_eq({"busy", sfx},  32'(g_busy),  32'(e_busy));
      check_eq({"done", sfx},  32'(g_done),  32'(e_done));
      if (!e_busy && req && !prev[i]) begin
         start[i] = cyc + 1;
         have[i]  = 1'b1;
      end
      prev[i] = req;
   endtask

   task automatic step(input bit ra, input bit rb);
      @(posedge clk_i);
      #1;
      req_a = ra;
      req_b = rb;
      cyc++;
      @(negedge clk_i);
      check_inst(0, ra, rst_n_a, busy_a, done_a);
      check_inst(1, rb, rst_n_b, busy_b, done_b);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_rst_n_a"}, 32'(rst_n_a), 32'd0);
      check_eq({tag, "_busy_a"},  32'(busy_a),  32'd1);
      check_eq({tag, "_done_a"},  32'(done_a),  32'd0);
      check_eq({tag, "_rst_n_b"}, 32'(rst_n_b), 32'd0);
      check_eq({tag, "_busy_b"},  32'(busy_b),  32'd1);
      check_eq({tag, "_done_b"},  32'(done_b),  32'd0);
   endtask

   // Called just after a negedge sample; release lands mid second half so that
   // the current cycle is power-on pulse cycle 1.
   task automatic do_reset(input int n_low);
      #1;
      arst_n_i = 1'b0;
      req_a    = 1'b0;
      req_b    = 1'b0;
      #1;
      check_reset_vals("arst_now");
      for (int j = 0; j < n_low; j++) begin
         @(posedge clk_i);
         #1;
         cyc++;
         @(negedge clk_i);
         check_reset_vals("arst_hold");
      end
      #2;
      arst_n_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start[i] = cyc;
         have[i]  = 1'b1;
         prev[i]  = 1'b0;
      end
   endtask

   function automatic bit model_busy(input int i, input int k);
      bit r, b, d;
      model_out(i, k, r, b, d);
      return b;
   endfunction

   function automatic bit model_done(input int i, input int k);
      bit r, b, d;
      model_out(i, k, r, b, d);
      return d;
   endfunction

   task automatic wait_idle_a();
      int guard;
      guard = 0;
      while ((model_busy(0, cyc + 1) || model_done(0, cyc + 1)) && guard < 50) begin
         step(1'b0, 1'b0);
         guard++;
      end
      step(1'b0, 1'b0);
   endtask

   initial begin
      int guard;
      bit ra, rb;

      // Power-on pulse with req low
      @(negedge clk_i);
      do_reset(2);
      repeat (10) step(1'b0, 1'b0);

      // Single request on both instances from IDLE
      step(1'b1, 1'b1);
      repeat (9) step(1'b0, 1'b0);

      // Toggling during ASSERT, then held high through completion
      wait_idle_a();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (12) step(1'b1, 1'b1);
      step(1'b0, 1'b0);

      // New edge exactly in the done cycle
      wait_idle_a();
      step(1'b1, 1'b0);
      guard = 0;
      while (!model_done(0, cyc + 1) && guard < 50) begin
         step(1'b0, 1'b0);
         guard++;
      end
      check_eq("reach_done_cycle", 32'(model_done(0, cyc + 1)), 32'd1);
      step(1'b1, 1'b1);
      repeat (10) step(1'b0, 1'b0);

      // Reset asserted mid-HOLDOFF
      wait_idle_a();
      step(1'b1, 1'b0);
      guard = 0;
      while ((cyc - start[0] < c_P_A) && guard < 50) begin
         step(1'b0, 1'b0);
         guard++;
      end
      check_eq("reach_holdoff", 32'(model_busy(0, cyc) && rst_n_a), 32'd1);
      do_reset(1);
      repeat (10) step(1'b0, 1'b0);

      // Randomized requests with occasional resets
      for (int n = 0; n < 600; n++) begin
         ra = ($urandom_range(0, 2) == 0);
         rb = ($urandom_range(0, 1) == 0);
         step(ra, rb);
         if ($urandom_range(0, 149) == 0) do_reset($urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
